// File: rtl/mem_arbiter.sv
// N-channel arbiter that merges upstream requesters onto one memory port, one transaction at a time.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin selection; otherwise the lowest-indexed channel wins.
module mem_arbiter #(
  parameter  int NUM_CH  = 2,
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  localparam int STRB_W  = DATA_W / 8,
  localparam int GRANT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH-1:0]          ch_instr,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  input  logic [NUM_CH*STRB_W-1:0]   ch_wstrb,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic [NUM_CH-1:0]          ch_ready,
  output logic                       mem_valid,
  output logic                       mem_instr,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [STRB_W-1:0]          mem_wstrb,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_ready,
  output logic [GRANT_W-1:0]         grant,
  output logic                       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                 req_instr_q, req_instr_d;
  logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
  logic [DATA_W-1:0]    req_wdata_q, req_wdata_d;
  logic [STRB_W-1:0]    req_wstrb_q, req_wstrb_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [GRANT_W-1:0]   grant_q, grant_d;
  logic [GRANT_W-1:0]   last_grant_q, last_grant_d;
  logic [NUM_CH-1:0]    ch_ready_q, ch_ready_d;
  logic                 mem_valid_q, mem_valid_d;
  logic                 busy_q, busy_d;

  logic                 sel_found_s;
  logic [GRANT_W-1:0]   sel_idx_s;
  logic                 sel_instr_s;
  logic [ADDR_W-1:0]    sel_addr_s;
  logic [DATA_W-1:0]    sel_wdata_s;
  logic [STRB_W-1:0]    sel_wstrb_s;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic [(2**GRANT_W)-1:0] valid_pad_s;
  logic [GRANT_W-1:0]      cand_s;
  logic                    hit_s;

  // Round-robin winner: first valid channel after last_grant, wrapping at NUM_CH-1.
  always_comb begin
    valid_pad_s = (2**GRANT_W)'(ch_valid);
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand_s      = GRANT_W'((int'(last_grant_q) + k) % NUM_CH);
      hit_s       = !sel_found_s && valid_pad_s[cand_s];
      sel_idx_s   = hit_s ? cand_s : sel_idx_s;
      sel_found_s = sel_found_s | hit_s;
    end
  end
`else
  // Fixed-priority winner: the lowest-indexed valid channel.
  always_comb begin
    sel_found_s = |ch_valid;
    sel_idx_s   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      sel_idx_s = ch_valid[i] ? GRANT_W'(i) : sel_idx_s;
    end
  end
`endif

  // Mux the winning channel's request fields.
  always_comb begin
    sel_instr_s = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_wstrb_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_instr_s = (sel_idx_s == GRANT_W'(i)) ? ch_instr[i] : sel_instr_s;
      sel_addr_s  = (sel_idx_s == GRANT_W'(i)) ? ch_addr[i*ADDR_W +: ADDR_W]  : sel_addr_s;
      sel_wdata_s = (sel_idx_s == GRANT_W'(i)) ? ch_wdata[i*DATA_W +: DATA_W] : sel_wdata_s;
      sel_wstrb_s = (sel_idx_s == GRANT_W'(i)) ? ch_wstrb[i*STRB_W +: STRB_W] : sel_wstrb_s;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = sel_found_s ? REQ : IDLE;
      REQ:     state_d = mem_ready ? RESP : REQ;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; outputs are decoded from the next state so they leave registers.
  always_comb begin
    req_instr_d  = req_instr_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_wstrb_d  = req_wstrb_q;
    rdata_d      = rdata_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (sel_found_s) begin
          req_instr_d = sel_instr_s;
          req_addr_d  = sel_addr_s;
          req_wdata_d = sel_wdata_s;
          req_wstrb_d = sel_wstrb_s;
          grant_d     = sel_idx_s;
        end else begin
          grant_d     = grant_q;
        end
      end
      REQ: begin
        if (mem_ready) begin
          rdata_d = mem_rdata;
        end else begin
          rdata_d = rdata_q;
        end
      end
      RESP:    last_grant_d = grant_q;
      default: last_grant_d = last_grant_q;
    endcase
    mem_valid_d = (state_d == REQ);
    busy_d      = (state_d != IDLE);
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ready_d[i] = (state_d == RESP) && (grant_d == GRANT_W'(i));
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_instr_q  <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_wstrb_q  <= '0;
      rdata_q      <= '0;
      grant_q      <= '0;
      last_grant_q <= GRANT_W'(NUM_CH - 1);
      ch_ready_q   <= '0;
      mem_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      req_instr_q  <= req_instr_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_wstrb_q  <= req_wstrb_d;
      rdata_q      <= rdata_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ch_ready_q   <= ch_ready_d;
      mem_valid_q  <= mem_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_instr = req_instr_q;
  assign mem_addr  = req_addr_q;
  assign mem_wdata = req_wdata_q;
  assign mem_wstrb = req_wstrb_q;
  assign ch_rdata  = rdata_q;
  assign ch_ready  = ch_ready_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

endmodule
